// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// key_debouncer : synchronizes and debounces an active-low push-button into
//                 a clean level, a one-cycle press strobe and a press toggle.
// Revision      : 1.0
// ============================================================================
module key_debouncer #(
    parameter  int DEBOUNCE_CYCLES = 1000000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic iKEY_n,
    output logic oLEVEL,
    output logic oPULSE,
    output logic oTOGGLE
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sync_meta;
    logic             sync_key;
    logic             key_pressed;
    logic             level_nxt;
    logic             pulse_nxt;
    logic             toggle_nxt;

    // Synchronizer flops idle at 1 so a key held through reset looks like a new press.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync_meta <= 1'b1;
            sync_key  <= 1'b1;
        end else begin
            sync_meta <= iKEY_n;
            sync_key  <= sync_meta;
        end
    end

    assign key_pressed = ~sync_key;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state   <= RELEASED;
            cnt     <= '0;
            oLEVEL  <= 1'b0;
            oPULSE  <= 1'b0;
            oTOGGLE <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            oLEVEL  <= level_nxt;
            oPULSE  <= pulse_nxt;
            oTOGGLE <= toggle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        level_nxt  = oLEVEL;
        pulse_nxt  = 1'b0;
        toggle_nxt = oTOGGLE;
        case (state)
            RELEASED: begin
                if (key_pressed) begin
                    state_nxt = CHECK_PRESS;
                    cnt_nxt   = '0;
                end
            end
            CHECK_PRESS: begin
                if (!key_pressed) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = PRESSED;
                    cnt_nxt    = '0;
                    level_nxt  = 1'b1;
                    pulse_nxt  = 1'b1;
                    toggle_nxt = ~oTOGGLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!key_pressed) begin
                    state_nxt = CHECK_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            CHECK_RELEASE: begin
                // Bouncing back to pressed re-enters PRESSED silently: no strobe.
                if (key_pressed) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
